// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for one shared registered ALU.
// Latency: ALU_LAT+2 cycles from accept to RSP_VALID. Backpressure: RSP_READY low holds RESP and blocks new grants.
// Optional grant counters are enabled by the ALU_ARB_STATS_EN macro.
module alu_arb_ctrl #(
  parameter int WIDTH   = 16,
  parameter int WFUN    = 4,
  parameter int WFLAG   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [WFUN-1:0]  REQ0_FUN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [WFUN-1:0]  REQ1_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [WFUN-1:0]  ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic [WFLAG-1:0] ALU_FLAGS,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [WFLAG-1:0] RSP_FLAGS,
  output logic             BUSY
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      GNT0_CNT,
  output logic [15:0]      GNT1_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

  state_t     state, next_state;
  logic       last_id;
  logic [2:0] lat_cnt;
  logic       any_req;
  logic       winner;
  logic       accept;

  assign any_req = REQ0_VALID | REQ1_VALID;
  // On a tie the requester that did not win last time goes next.
  assign winner  = (REQ0_VALID & REQ1_VALID) ? ~last_id : ~REQ0_VALID;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (any_req) next_state = EXEC;
      EXEC: if (lat_cnt <= 3'd1) next_state = CAPT;
      CAPT: next_state = RESP;
      RESP: if (RSP_READY) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accept is gated by RST so nothing is granted while reset is held.
  always_comb begin
    accept     = (state == IDLE) && any_req && !RST;
    REQ0_READY = accept && !winner;
    REQ1_READY = accept && winner;
    BUSY       = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FLAGS <= '0;
      last_id   <= 1'b1;
      lat_cnt   <= 3'd0;
    end else begin
      if (accept) begin
        ALU_A   <= winner ? REQ1_A   : REQ0_A;
        ALU_B   <= winner ? REQ1_B   : REQ0_B;
        ALU_FUN <= winner ? REQ1_FUN : REQ0_FUN;
        RSP_ID  <= winner;
        last_id <= winner;
        lat_cnt <= LAT_LOAD;
      end
      if (state == EXEC) lat_cnt <= lat_cnt - 3'd1;
      if (state == CAPT) begin
        RSP_DATA  <= ALU_OUT;
        RSP_FLAGS <= ALU_FLAGS;
        RSP_VALID <= 1'b1;
      end
      if (state == RESP && RSP_READY) RSP_VALID <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      GNT0_CNT <= '0;
      GNT1_CNT <= '0;
    end else begin
      if (REQ0_READY && GNT0_CNT != 16'hFFFF) GNT0_CNT <= GNT0_CNT + 16'd1;
      if (REQ1_READY && GNT1_CNT != 16'hFFFF) GNT1_CNT <= GNT1_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_arb_ctrl.md
Name: alu_arb_ctrl

Overview:
Two-requester arbiter and sequencer that shares one registered 16-bit ALU datapath (A, B, ALU_FUN in; ALU_OUT and 4 flags out).
- Accepts operations over valid/ready request ports and grants them round-robin.
- Drives the ALU operands and function code, waits the ALU latency, then captures the result and flags.
- Returns the result over a valid/ready response port tagged with the requester ID.
- Sits between the instruction/test sequencers and the ALU instance; only one operation is in flight at a time.

Parameters:
WIDTH, 16, operand/result width
WFUN, 4, ALU function code width
WFLAG, 4, flag vector width {Shift, CMP, Logic, Arith}
ALU_LAT, 1, clock edges from operands driven to ALU_OUT valid (1..7)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  synchronous, active-high reset
REQ0_VALID  in  1  requester 0 has an operation
REQ0_READY  out  1  one-cycle accept pulse to requester 0
REQ0_A / REQ0_B  in  WIDTH  requester 0 operands
REQ0_FUN  in  WFUN  requester 0 function code
REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_FUN  same as requester 0, for requester 1
ALU_A / ALU_B  out  WIDTH  registered operands to ALU
ALU_FUN  out  WFUN  registered function to ALU
ALU_OUT  in  WIDTH  ALU result
ALU_FLAGS  in  WFLAG  ALU flags {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag}
RSP_VALID  out  1  response available
RSP_READY  in  1  consumer accepts response
RSP_ID  out  1  requester that issued the op
RSP_DATA  out  WIDTH  captured ALU_OUT
RSP_FLAGS  out  WFLAG  captured ALU_FLAGS
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST high at a rising edge): all outputs go to 0 and the FSM goes to IDLE. The round-robin pointer LAST_ID resets to 1, so requester 0 wins the first tie. This applies mid-operation: any in-flight op and pending response are dropped with no response.
- FSM states:
  - IDLE: if any REQx_VALID is high, pick a winner, assert REQx_READY=1 for this cycle only, and register REQx_A/B/FUN into ALU_A/B/FUN and the winner into RSP_ID. Set LAST_ID=winner, load LAT_CNT=ALU_LAT, go to EXEC. Otherwise stay in IDLE.
  - EXEC: decrement LAT_CNT each cycle; when LAT_CNT reaches 1, go to CAPT. ALU_A/B/FUN are held stable throughout EXEC.
  - CAPT: register ALU_OUT into RSP_DATA and ALU_FLAGS into RSP_FLAGS, set RSP_VALID=1, go to RESP.
  - RESP: hold RSP_* stable while RSP_READY=0. On RSP_VALID&&RSP_READY, clear RSP_VALID and go to IDLE.
- Arbitration:
  - Only one REQ_VALID high: that requester wins.
  - Both high: the requester != LAST_ID wins.
  - A requester keeps VALID and its operands stable until READY. READY is never asserted outside IDLE.
- Latency: from the accepting edge to RSP_VALID=1 is ALU_LAT+2 cycles. The minimum cycle time per op is ALU_LAT+3 when RSP_READY is held high.
- Throughput: the next grant can occur no earlier than the IDLE cycle following the response handshake. There is no back-to-back overlap.
- Widths: data is passed through unmodified. The controller performs no arithmetic on operands. LAT_CNT is 3 bits.
- Illegal ALU_FUN codes are forwarded as-is; the result is whatever the ALU produces.
- RSP_READY high while RSP_VALID is low is ignored.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined: adds outputs GNT0_CNT and GNT1_CNT (16 bits each). Each counter increments on its requester's accept pulse, saturates at 16'hFFFF, and is cleared by RST.
- Not defined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Single op, ALU_LAT=1, ALU = ALU_16bit instance, RSP_READY=1. REQ0: A=10, B=5, FUN=4'b0101 -> REQ0_READY pulses one cycle; 3 cycles later RSP_VALID=1, RSP_DATA=16'd15, RSP_ID=0, Logic flag set.
2. Comparison op on REQ1: A=10, B=5, FUN=4'b1011 -> RSP_DATA=16'd2, RSP_ID=1, CMP flag set.
3. Tie: REQ0 and REQ1 both valid from reset, each holding OR ops (A=10, B=5 / A=3, B=12) -> first response RSP_ID=0, RSP_DATA=15; second RSP_ID=1, RSP_DATA=15; no third grant.
4. Backpressure: RSP_READY=0 for 10 cycles after RSP_VALID -> RSP_DATA/FLAGS/ID stable, BUSY=1, no REQx_READY pulse. RSP_READY=1 -> handshake, next grant in the following IDLE cycle.
5. Reset mid-op: assert RST during EXEC -> next edge gives all outputs 0, BUSY=0, no response; first grant after reset goes to REQ0 on a tie.
6. With ALU_ARB_STATS_EN and ALU_LAT=3: five ops alternating requesters -> GNT0_CNT=3, GNT1_CNT=2, each latency 5 cycles.
